// File: rtl/reverb_pkg.sv
// Shared definitions for the reverb parameter sequencer.
//   PARAM_W      : width of every coefficient and target (unsigned)
//   param_idx_e  : parameter index, also the bit position in the one-hot paramtype
//   upd_e        : paramvalueupdate request encodings polled by the HPS
//   ramp_state_e : per-sample sweep states (one live value written per state)
//   req_state_e  : encoder request hold states
package reverb_pkg;

    localparam int unsigned PARAM_W = 24;

    typedef enum logic [1:0] {
        DECAY    = 2'd0,
        DAMP     = 2'd1,
        MIX      = 2'd2,
        PREDELAY = 2'd3
    } param_idx_e;

    typedef enum logic [1:0] {
        UPD_NONE = 2'b00,
        UPD_INC  = 2'b01,
        UPD_DEC  = 2'b10
    } upd_e;

    typedef enum logic [2:0] {
        RAMP_IDLE,
        RAMP_S0,
        RAMP_S1,
        RAMP_S2,
        RAMP_S3
    } ramp_state_e;

    typedef enum logic {
        REQ_IDLE,
        REQ_HOLD
    } req_state_e;

endpackage

// File: rtl/param_ramp_step.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
//   cur  : present live value
//   tgt  : snapshot target
//   step : maximum change allowed this sample
//   nxt  : new live value; lands exactly on tgt when within one step,
//          so it never overshoots and never wraps
module param_ramp_step
    import reverb_pkg::*;
(
    input  logic [PARAM_W-1:0] cur,
    input  logic [PARAM_W-1:0] tgt,
    input  logic [PARAM_W-1:0] step,
    output logic [PARAM_W-1:0] nxt
);

    logic [PARAM_W:0] diff;
    logic [PARAM_W:0] mag;

    always_comb begin
        // One extra bit so the sign of (tgt - cur) is visible.
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[PARAM_W] ? -diff : diff;
        if (mag <= {1'b0, step}) begin
            nxt = tgt;
        end else if (diff[PARAM_W]) begin
            nxt = cur - step;
        end else begin
            nxt = cur + step;
        end
    end

endmodule

// File: rtl/reverb_param_sequencer.sv
// Front-panel request generation and per-sample coefficient ramping.
//   clk, reset              : system clock, synchronous active-high reset
//   sample_tick             : one pulse per audio sample
//   btn_next / btn_prev     : select next / previous parameter
//   enc_up / enc_down       : request increment / decrement of selected parameter
//   *_tgt                   : HPS-written targets
//   paramtype               : one-hot selected parameter (decay, damp, mix, predelay)
//   paramvalueupdate        : held request to the HPS (01 inc, 10 dec, 00 idle)
//   *_val                   : live slew-limited coefficients
//   sweep_done              : pulse after all four live values updated
//   overrun                 : sticky, a sample tick was dropped
module reverb_param_sequencer
    import reverb_pkg::*;
#(
    parameter logic [PARAM_W-1:0] STEP        = 24'h000400,
    parameter logic [PARAM_W-1:0] PD_STEP     = 24'h000001,
    parameter int unsigned        HOLD_CYCLES = 5000,
    parameter logic [PARAM_W-1:0] RST_DECAY   = 24'h000000,
    parameter logic [PARAM_W-1:0] RST_DAMP    = 24'h000000,
    parameter logic [PARAM_W-1:0] RST_MIX     = 24'h000000,
    parameter logic [PARAM_W-1:0] RST_PD      = 24'h000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               enc_up,
    input  logic               enc_down,
    input  logic [PARAM_W-1:0] decay_tgt,
    input  logic [PARAM_W-1:0] damp_tgt,
    input  logic [PARAM_W-1:0] mix_tgt,
    input  logic [PARAM_W-1:0] pd_tgt,
    output logic [3:0]         paramtype,
    output logic [1:0]         paramvalueupdate,
    output logic [PARAM_W-1:0] decay_val,
    output logic [PARAM_W-1:0] damp_val,
    output logic [PARAM_W-1:0] mix_val,
    output logic [PARAM_W-1:0] pd_val,
    output logic               sweep_done,
    output logic               overrun
);

    req_state_e         req_q, req_d;
    upd_e               upd_q, upd_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [3:0]         pt_q, pt_d;

    ramp_state_e        ramp_q, ramp_d;
    logic               pend_q, pend_d;
    logic               ovr_q, ovr_d;
    logic               done_q, done_d;
    logic [PARAM_W-1:0] snap_q [4];
    logic [PARAM_W-1:0] snap_d [4];
    logic [PARAM_W-1:0] decay_q, decay_d, damp_q, damp_d;
    logic [PARAM_W-1:0] mix_q, mix_d, pd_q, pd_d;

    param_idx_e         sel;
    logic [PARAM_W-1:0] step_cur, step_tgt, step_amt, step_nxt;

    // Select and encoder request; select is frozen while a request is held.
    always_comb begin
        pt_d  = pt_q;
        req_d = req_q;
        upd_d = upd_q;
        cnt_d = cnt_q;
        if (req_q == REQ_IDLE && (btn_next ^ btn_prev)) begin
            pt_d = btn_next ? {pt_q[2:0], pt_q[3]} : {pt_q[0], pt_q[3:1]};
        end
        case (req_q)
            REQ_IDLE: begin
                if (enc_up ^ enc_down) begin
                    req_d = REQ_HOLD;
                    upd_d = enc_up ? UPD_INC : UPD_DEC;
                    cnt_d = HOLD_CYCLES;
                end
            end
            REQ_HOLD: begin
                if (cnt_q <= 32'd1) begin
                    req_d = REQ_IDLE;
                    upd_d = UPD_NONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                req_d = REQ_IDLE;
                upd_d = UPD_NONE;
            end
        endcase
    end

    // Shared step unit operand mux, driven purely by the sweep state.
    always_comb begin
        case (ramp_q)
            RAMP_S1: sel = DAMP;
            RAMP_S2: sel = MIX;
            RAMP_S3: sel = PREDELAY;
            default: sel = DECAY;
        endcase
        case (sel)
            DAMP:     begin step_cur = damp_q;  step_tgt = snap_q[1]; end
            MIX:      begin step_cur = mix_q;   step_tgt = snap_q[2]; end
            PREDELAY: begin step_cur = pd_q;    step_tgt = snap_q[3]; end
            default:  begin step_cur = decay_q; step_tgt = snap_q[0]; end
        endcase
        step_amt = (sel == PREDELAY) ? PD_STEP : STEP;
    end

    param_ramp_step u_step (
        .cur  (step_cur),
        .tgt  (step_tgt),
        .step (step_amt),
        .nxt  (step_nxt)
    );

    always_comb begin
        logic take_snap;
        take_snap = 1'b0;
        ramp_d    = ramp_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        done_d    = 1'b0;
        snap_d    = snap_q;
        decay_d   = decay_q;
        damp_d    = damp_q;
        mix_d     = mix_q;
        pd_d      = pd_q;

        case (ramp_q)
            RAMP_IDLE: begin
                if (sample_tick) begin
                    take_snap = 1'b1;
                    ramp_d    = RAMP_S0;
                end
            end
            RAMP_S0: ramp_d = RAMP_S1;
            RAMP_S1: ramp_d = RAMP_S2;
            RAMP_S2: ramp_d = RAMP_S3;
            RAMP_S3: begin
                done_d = 1'b1;
                // A pending tick, or one landing right now, restarts without an idle cycle.
                if (pend_q || sample_tick) begin
                    take_snap = 1'b1;
                    ramp_d    = RAMP_S0;
                    pend_d    = 1'b0;
                end else begin
                    ramp_d = RAMP_IDLE;
                end
            end
            default: ramp_d = RAMP_IDLE;
        endcase

        if (ramp_q != RAMP_IDLE && sample_tick) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else if (ramp_q != RAMP_S3) begin
                pend_d = 1'b1;
            end
        end

        if (take_snap) begin
            snap_d[0] = decay_tgt;
            snap_d[1] = damp_tgt;
            snap_d[2] = mix_tgt;
            snap_d[3] = pd_tgt;
        end

        if (ramp_q != RAMP_IDLE) begin
            case (sel)
                DAMP:     damp_d  = step_nxt;
                MIX:      mix_d   = step_nxt;
                PREDELAY: pd_d    = step_nxt;
                default:  decay_d = step_nxt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= REQ_IDLE;
            upd_q   <= UPD_NONE;
            cnt_q   <= '0;
            pt_q    <= 4'b0001;
            ramp_q  <= RAMP_IDLE;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            snap_q  <= '{default: '0};
            decay_q <= RST_DECAY;
            damp_q  <= RST_DAMP;
            mix_q   <= RST_MIX;
            pd_q    <= RST_PD;
        end else begin
            req_q   <= req_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            ramp_q  <= ramp_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            snap_q  <= snap_d;
            decay_q <= decay_d;
            damp_q  <= damp_d;
            mix_q   <= mix_d;
            pd_q    <= pd_d;
        end
    end

    assign paramtype        = pt_q;
    assign paramvalueupdate = upd_q;
    assign decay_val        = decay_q;
    assign damp_val         = damp_q;
    assign mix_val          = mix_q;
    assign pd_val           = pd_q;
    assign sweep_done       = done_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_reverb_param_sequencer.sv
// Self-checking bench for reverb_param_sequencer: expected live-value sets are
// queued when a tick is driven and compared when sweep_done is observed.
module tb_reverb_param_sequencer;

    localparam int unsigned HOLD      = 4;
    localparam logic [23:0] STEP_P    = 24'h000400;
    localparam logic [23:0] PD_STEP_P = 24'h000001;

    logic        clk = 1'b0;
    logic        reset, sample_tick, btn_next, btn_prev, enc_up, enc_down;
    logic [23:0] decay_tgt, damp_tgt, mix_tgt, pd_tgt;
    logic [3:0]  paramtype;
    logic [1:0]  paramvalueupdate;
    logic [23:0] decay_val, damp_val, mix_val, pd_val;
    logic        sweep_done, overrun;

    int errors = 0;
    int checks = 0;

    logic [95:0] exp_q [$];
    logic [23:0] m_decay, m_damp, m_mix, m_pd;

    reverb_param_sequencer #(
        .STEP        (STEP_P),
        .PD_STEP     (PD_STEP_P),
        .HOLD_CYCLES (HOLD),
        .RST_DECAY   (24'h000000),
        .RST_DAMP    (24'h000000),
        .RST_MIX     (24'h000000),
        .RST_PD      (24'h000000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_tick      (sample_tick),
        .btn_next         (btn_next),
        .btn_prev         (btn_prev),
        .enc_up           (enc_up),
        .enc_down         (enc_down),
        .decay_tgt        (decay_tgt),
        .damp_tgt         (damp_tgt),
        .mix_tgt          (mix_tgt),
        .pd_tgt           (pd_tgt),
        .paramtype        (paramtype),
        .paramvalueupdate (paramvalueupdate),
        .decay_val        (decay_val),
        .damp_val         (damp_val),
        .mix_val          (mix_val),
        .pd_val           (pd_val),
        .sweep_done       (sweep_done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [23:0] model_step(input logic [23:0] cur,
                                               input logic [23:0] tgt,
                                               input logic [23:0] step);
        int c, t, s;
        c = int'(cur);
        t = int'(tgt);
        s = int'(step);
        if (t - c > s) return 24'(c + s);
        if (c - t > s) return 24'(c - s);
        return tgt;
    endfunction

    task automatic push_expect();
        m_decay = model_step(m_decay, decay_tgt, STEP_P);
        m_damp  = model_step(m_damp,  damp_tgt,  STEP_P);
        m_mix   = model_step(m_mix,   mix_tgt,   STEP_P);
        m_pd    = model_step(m_pd,    pd_tgt,    PD_STEP_P);
        exp_q.push_back({m_decay, m_damp, m_mix, m_pd});
    endtask

    task automatic model_reset();
        m_decay = '0; m_damp = '0; m_mix = '0; m_pd = '0;
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    // Waits (bounded) for sweep_done, then pops and compares one expectation.
    task automatic wait_sweep(input string name, output int lat);
        logic [95:0] e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (sweep_done !== 1'b1 && lat < 20);
        checks++;
        if (sweep_done !== 1'b1) begin
            errors++;
            $display("FAIL %s: sweep_done not seen within %0d cycles", name, lat);
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: sweep_done with nothing expected", name);
        end else begin
            e = exp_q.pop_front();
            if ({decay_val, damp_val, mix_val, pd_val} !== e) begin
                errors++;
                $display("FAIL %s: live values got %h expected %h", name,
                         {decay_val, damp_val, mix_val, pd_val}, e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (paramtype !== 4'b0001) begin errors++; $display("FAIL reset_paramtype: got %b expected 0001", paramtype); end
        checks++; if (paramvalueupdate !== 2'b00) begin errors++; $display("FAIL reset_update: got %b expected 00", paramvalueupdate); end
        checks++; if (decay_val !== 24'h0) begin errors++; $display("FAIL reset_decay: got %h expected 000000", decay_val); end
        checks++; if (damp_val !== 24'h0) begin errors++; $display("FAIL reset_damp: got %h expected 000000", damp_val); end
        checks++; if (mix_val !== 24'h0) begin errors++; $display("FAIL reset_mix: got %h expected 000000", mix_val); end
        checks++; if (pd_val !== 24'h0) begin errors++; $display("FAIL reset_pd: got %h expected 000000", pd_val); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_decay_ramp();
        logic [23:0] tab [5];
        int lat;
        tab = '{24'h000400, 24'h000800, 24'h000C00, 24'h001000, 24'h001000};
        decay_tgt = 24'h001000; damp_tgt = '0; mix_tgt = '0; pd_tgt = '0;
        for (int i = 0; i < 5; i++) begin
            push_expect();
            pulse_tick();
            wait_sweep("decay_ramp", lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL decay_latency: sweep_done %0d cycles after tick edge, expected 4", lat); end
            checks++; if (decay_val !== tab[i]) begin errors++; $display("FAIL decay_value: got %h expected %h", decay_val, tab[i]); end
        end
    endtask

    task automatic test_damp_down();
        logic [23:0] tab [5];
        int lat;
        tab = '{24'h000400, 24'h000500, 24'h000100, 24'h000000, 24'h000000};
        damp_tgt = 24'h000500;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) damp_tgt = 24'h000000;
            push_expect();
            pulse_tick();
            wait_sweep("damp_down", lat);
            checks++; if (damp_val !== tab[i]) begin errors++; $display("FAIL damp_value: got %h expected %h", damp_val, tab[i]); end
        end
    endtask

    task automatic test_select_lockout();
        int high;
        do_reset(2);
        btn_prev = 1'b1;
        @(negedge clk);
        btn_prev = 1'b0;
        checks++; if (paramtype !== 4'b1000) begin errors++; $display("FAIL select_prev_wrap: got %b expected 1000", paramtype); end

        enc_up = 1'b1;
        @(negedge clk);
        enc_up = 1'b0;
        high = 0;
        for (int i = 0; i < 7; i++) begin
            if (paramvalueupdate === 2'b01) high++;
            btn_next = (i == 1);
            @(negedge clk);
        end
        checks++; if (high != 4) begin errors++; $display("FAIL hold_length: inc asserted %0d cycles, expected 4", high); end
        checks++; if (paramtype !== 4'b1000) begin errors++; $display("FAIL select_lockout: got %b expected 1000", paramtype); end
        checks++; if (paramvalueupdate !== 2'b00) begin errors++; $display("FAIL hold_release: got %b expected 00", paramvalueupdate); end

        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        checks++; if (paramtype !== 4'b0001) begin errors++; $display("FAIL select_next_wrap: got %b expected 0001", paramtype); end

        btn_next = 1'b1; btn_prev = 1'b1;
        @(negedge clk);
        btn_next = 1'b0; btn_prev = 1'b0;
        checks++; if (paramtype !== 4'b0001) begin errors++; $display("FAIL select_both: got %b expected 0001", paramtype); end

        enc_down = 1'b1;
        @(negedge clk);
        enc_down = 1'b0;
        checks++; if (paramvalueupdate !== 2'b10) begin errors++; $display("FAIL dec_request: got %b expected 10", paramvalueupdate); end
        repeat (5) @(negedge clk);
        enc_up = 1'b1; enc_down = 1'b1;
        @(negedge clk);
        enc_up = 1'b0; enc_down = 1'b0;
        checks++; if (paramvalueupdate !== 2'b00) begin errors++; $display("FAIL enc_both: got %b expected 00", paramvalueupdate); end
    endtask

    task automatic test_tick_overlap();
        int lat;
        int seen;
        decay_tgt = 24'h001000; damp_tgt = '0; mix_tgt = 24'h000900; pd_tgt = 24'd5;
        push_expect();
        push_expect();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        wait_sweep("overlap_first", lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL overlap_first_latency: got %0d expected 1", lat); end
        wait_sweep("overlap_second", lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL overlap_second_latency: got %0d expected 4", lat); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL dropped_tick: %0d extra sweeps, expected 0", seen); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overlap_queue: %0d sweeps outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [23:0] exp_decay;
        int seen;
        int lat;
        exp_decay = model_step(m_decay, decay_tgt, STEP_P);
        pulse_tick();
        @(negedge clk);
        checks++; if (decay_val !== exp_decay) begin errors++; $display("FAIL mid_decay_written: got %h expected %h", decay_val, exp_decay); end
        checks++; if (mix_val !== m_mix) begin errors++; $display("FAIL mid_mix_untouched: got %h expected %h", mix_val, m_mix); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({decay_val, damp_val, mix_val, pd_val} !== 96'h0) begin errors++; $display("FAIL mid_reset_values: got %h expected 0", {decay_val, damp_val, mix_val, pd_val}); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1 || mix_val !== 24'h0 || pd_val !== 24'h0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_resume: %0d cycles with activity, expected 0", seen); end
        push_expect();
        pulse_tick();
        wait_sweep("post_reset_sweep", lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL post_reset_latency: got %0d expected 4", lat); end
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; enc_up = 1'b0; enc_down = 1'b0;
        decay_tgt = '0; damp_tgt = '0; mix_tgt = '0; pd_tgt = '0;
        model_reset();
        test_reset();
        test_decay_ramp();
        test_damp_down();
        test_select_lockout();
        test_tick_overlap();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
